// File: rtl/cache_miss_arb.sv
// cache_miss_arb: miss controller and shared line-read port arbiter for the split L1.
// One icache/tags pair and one dcache/tags pair share a single 64-bit line-read port.
// A granted miss runs REQ (wait for mem_ack) then FILL (one-cycle fill strobe to the owner).
// Optional macro CACHE_ARB_RR_EN: round-robin arbitration on simultaneous misses
// (last_owner register). Without it, the data side has fixed priority over the
// instruction side.
module cache_miss_arb #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             imiss,
    input  logic [31:0]      iaddr,
    input  logic             dvalid,
    input  logic             dmiss,
    input  logic [31:0]      daddr,
    output logic             mem_req,
    output logic [31:0]      mem_addr,
    input  logic             mem_ack,
    input  logic [63:0]      mem_rdata,
    output logic [63:0]      line,
    output logic             ifill,
    output logic             dfill,
    output logic             istall,
    output logic             dstall,
    output logic [CNT_W-1:0] imiss_cnt,
    output logic [CNT_W-1:0] dmiss_cnt
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 64;
    localparam logic [AW-1:0]    LINE_MASK = {{(AW-3){1'b1}}, 3'b000};
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               owner_d_q, owner_d_d;   // 1: data side owns the fetch
    logic               mem_req_q, mem_req_d;
    logic [AW-1:0]      mem_addr_q, mem_addr_d;
    logic [DW-1:0]      line_q, line_d;
    logic               ifill_q, ifill_d;
    logic               dfill_q, dfill_d;
    logic [CNT_W-1:0]   icnt_q, icnt_d;
    logic [CNT_W-1:0]   dcnt_q, dcnt_d;
    logic               ireq_c, dreq_c, grant_d_c;
`ifdef CACHE_ARB_RR_EN
    logic               last_d_q, last_d_d;     // 1: data side was granted last
`endif

    // Request terms and grant choice for the IDLE cycle
    always_comb begin
        ireq_c = imiss;
        dreq_c = dvalid & dmiss;
`ifdef CACHE_ARB_RR_EN
        grant_d_c = dreq_c & (~ireq_c | ~last_d_q);
`else
        grant_d_c = dreq_c;
`endif
    end

    // Next-state and registered-output computation
    always_comb begin
        state_d    = state_q;
        owner_d_d  = owner_d_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        line_d     = line_q;
        ifill_d    = 1'b0;
        dfill_d    = 1'b0;
        icnt_d     = icnt_q;
        dcnt_d     = dcnt_q;
`ifdef CACHE_ARB_RR_EN
        last_d_d   = last_d_q;
`endif
        case (state_q)
            IDLE: begin
                if (dreq_c || ireq_c) begin
                    owner_d_d  = grant_d_c;
                    mem_addr_d = grant_d_c ? (daddr & LINE_MASK) : (iaddr & LINE_MASK);
                    mem_req_d  = 1'b1;
                    state_d    = REQ;
`ifdef CACHE_ARB_RR_EN
                    last_d_d   = grant_d_c;
`endif
                    if (grant_d_c) begin
                        if (dcnt_q != CNT_MAX) dcnt_d = dcnt_q + CNT_W'(1);
                    end else begin
                        if (icnt_q != CNT_MAX) icnt_d = icnt_q + CNT_W'(1);
                    end
                end
            end
            REQ: begin
                if (mem_ack) begin
                    line_d    = mem_rdata;
                    mem_req_d = 1'b0;
                    ifill_d   = ~owner_d_q;
                    dfill_d   = owner_d_q;
                    state_d   = FILL;
                end
            end
            FILL: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_d_q  <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            line_q     <= '0;
            ifill_q    <= 1'b0;
            dfill_q    <= 1'b0;
            icnt_q     <= '0;
            dcnt_q     <= '0;
`ifdef CACHE_ARB_RR_EN
            last_d_q   <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            owner_d_q  <= owner_d_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            line_q     <= line_d;
            ifill_q    <= ifill_d;
            dfill_q    <= dfill_d;
            icnt_q     <= icnt_d;
            dcnt_q     <= dcnt_d;
`ifdef CACHE_ARB_RR_EN
            last_d_q   <= last_d_d;
`endif
        end
    end

    // Output wiring; stalls follow the miss inputs combinationally
    always_comb begin
        mem_req   = mem_req_q;
        mem_addr  = mem_addr_q;
        line      = line_q;
        ifill     = ifill_q;
        dfill     = dfill_q;
        imiss_cnt = icnt_q;
        dmiss_cnt = dcnt_q;
        istall    = rst | ireq_c;
        dstall    = rst | dreq_c;
    end

endmodule

// File: tb/tb_cache_miss_arb.sv
// tb_cache_miss_arb: directed and randomized checks of cache_miss_arb against a
// transaction-level reference model (grant order, line address, fill, counters, stall length).
module tb_cache_miss_arb;

    localparam int unsigned CW   = 2;
    localparam int          MAXC = 3;

    logic          clk;
    logic          rst;
    logic          imiss;
    logic [31:0]   iaddr;
    logic          dvalid;
    logic          dmiss;
    logic [31:0]   daddr;
    logic          mem_req;
    logic [31:0]   mem_addr;
    logic          mem_ack;
    logic [63:0]   mem_rdata;
    logic [63:0]   line;
    logic          ifill;
    logic          dfill;
    logic          istall;
    logic          dstall;
    logic [CW-1:0] imiss_cnt;
    logic [CW-1:0] dmiss_cnt;

    int n_vec = 0;
    int n_err = 0;
    int m_icnt = 0;
    int m_dcnt = 0;
`ifdef CACHE_ARB_RR_EN
    bit m_last_d = 1'b1;
`endif

    cache_miss_arb #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .imiss(imiss), .iaddr(iaddr),
        .dvalid(dvalid), .dmiss(dmiss), .daddr(daddr),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .line(line), .ifill(ifill), .dfill(dfill),
        .istall(istall), .dstall(dstall),
        .imiss_cnt(imiss_cnt), .dmiss_cnt(dmiss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic side_stall(input bit is_d);
        return is_d ? dstall : istall;
    endfunction

    function automatic int sat(input int v);
        return (v < MAXC) ? v + 1 : v;
    endfunction

    task automatic drop(input bit is_d);
        if (is_d) begin
            dmiss  = 1'b0;
            dvalid = 1'($urandom_range(0, 1));
        end else begin
            imiss = 1'b0;
        end
    endtask

    task automatic chk_cnts();
        chk("imiss_cnt", 64'(imiss_cnt), 64'(m_icnt));
        chk("dmiss_cnt", 64'(dmiss_cnt), 64'(m_dcnt));
    endtask

    task automatic do_reset();
        rst = 1'b1; imiss = 1'b0; dvalid = 1'b0; dmiss = 1'b0; mem_ack = 1'b0;
        tick();
        tick();
        chk("rst_mem_req", 64'(mem_req), 64'(0));
        chk("rst_mem_addr", 64'(mem_addr), 64'(0));
        chk("rst_line", line, 64'(0));
        chk("rst_fills", 64'({ifill, dfill}), 64'(0));
        chk("rst_istall", 64'(istall), 64'(1));
        chk("rst_dstall", 64'(dstall), 64'(1));
        m_icnt = 0;
        m_dcnt = 0;
`ifdef CACHE_ARB_RR_EN
        m_last_d = 1'b1;
`endif
        chk_cnts();
        rst = 1'b0;
        #1;
        chk("idle_istall", 64'(istall), 64'(0));
        chk("idle_dstall", 64'(dstall), 64'(0));
    endtask

    // Entered at the negedge of the IDLE cycle in which this side gets the grant.
    task automatic serve(input bit is_d, input logic [31:0] addr, input int dly,
                         input logic [63:0] data, input bit drop_g, input bit xack,
                         input bit odrop);
        int stalls;
        logic [31:0] laddr;
        laddr = addr & 32'hFFFF_FFF8;
        #1;
        chk("grant_stall", 64'(side_stall(is_d)), 64'(1));
        stalls = 1;
        tick();
        mem_ack = 1'b0;
        chk("req_up", 64'(mem_req), 64'(1));
        chk("req_addr", 64'(mem_addr), 64'(laddr));
        chk("req_nofill", 64'({ifill, dfill}), 64'(0));
        if (is_d) m_dcnt = sat(m_dcnt);
        else      m_icnt = sat(m_icnt);
`ifdef CACHE_ARB_RR_EN
        m_last_d = is_d;
`endif
        chk_cnts();
        if (drop_g) drop(is_d);
        for (int i = 0; i < dly; i++) begin
            #1 stalls += int'(side_stall(is_d));
            tick();
            chk("req_hold", 64'(mem_req), 64'(1));
            chk("addr_hold", 64'(mem_addr), 64'(laddr));
            chk("wait_nofill", 64'({ifill, dfill}), 64'(0));
        end
        #1 stalls += int'(side_stall(is_d));
        mem_ack   = 1'b1;
        mem_rdata = data;
        if (odrop) drop(!is_d);
        tick();
        mem_ack   = xack;
        mem_rdata = ~data;
        chk("fill_i", 64'(ifill), 64'(!is_d));
        chk("fill_d", 64'(dfill), 64'(is_d));
        chk("fill_line", line, data);
        chk("fill_req_low", 64'(mem_req), 64'(0));
        #1 stalls += int'(side_stall(is_d));
        tick();
        mem_ack = 1'b0;
        chk("after_nofill", 64'({ifill, dfill}), 64'(0));
        chk("after_req_low", 64'(mem_req), 64'(0));
        chk("after_line", line, data);
        drop(is_d);
        #1;
        chk("hit_stall", 64'(side_stall(is_d)), 64'(0));
        if (!drop_g) chk("stall_len", 64'(stalls), 64'(dly + 3));
    endtask

    task automatic txn(input bit ri, input bit rd, input logic [31:0] ia, input logic [31:0] da,
                       input int d1, input int d2, input logic [63:0] w1, input logic [63:0] w2,
                       input bit dg1, input bit dg2, input bit xa1, input bit xa2,
                       input bit odrop, input bit idle_ack);
        bit first_d;
        bit both;
        both  = ri && rd;
        imiss = ri;
        iaddr = ia;
        daddr = da;
        if (rd) begin
            dvalid = 1'b1;
            dmiss  = 1'b1;
        end else begin
            dvalid = 1'($urandom_range(0, 1));
            dmiss  = dvalid ? 1'b0 : 1'($urandom_range(0, 1));
        end
        mem_ack   = idle_ack;
        mem_rdata = {$urandom, $urandom};
        #1;
        chk("req_istall", 64'(istall), 64'(ri));
        chk("req_dstall", 64'(dstall), 64'(rd));
        if (!ri && !rd) begin
            tick();
            mem_ack = 1'b0;
            chk("noreq_mem_req", 64'(mem_req), 64'(0));
            chk("noreq_fills", 64'({ifill, dfill}), 64'(0));
            return;
        end
`ifdef CACHE_ARB_RR_EN
        first_d = rd && !(ri && m_last_d);
`else
        first_d = rd;
`endif
        serve(first_d, first_d ? da : ia, d1, w1, dg1, xa1, odrop && both);
        if (both && !odrop) serve(!first_d, first_d ? ia : da, d2, w2, dg2, xa2, 1'b0);
        tick();
        chk("end_mem_req", 64'(mem_req), 64'(0));
        chk("end_fills", 64'({ifill, dfill}), 64'(0));
    endtask

    initial begin
        rst = 1'b1; imiss = 1'b0; iaddr = '0; dvalid = 1'b0; dmiss = 1'b0; daddr = '0;
        mem_ack = 1'b0; mem_rdata = '0;

        do_reset();
        tick();
        chk("idle_mem_req", 64'(mem_req), 64'(0));

        // Single instruction miss, ack two cycles after mem_req
        txn(1'b1, 1'b0, 32'h0040_0014, 32'h0, 2, 0, 64'h1122_3344_5566_7788, 64'h0,
            1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Simultaneous requests straight after reset
        do_reset();
        txn(1'b1, 1'b1, 32'h0040_0000, 32'h1000_0008, 1, 1,
            64'hDDDD_0000_1111_2222, 64'hAAAA_5555_3333_4444,
            1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Ack in the same cycle as mem_req: three-cycle stall
        txn(1'b1, 1'b0, 32'h0000_1238, 32'h0, 0, 0, 64'h0123_4567_89AB_CDEF, 64'h0,
            1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset while in REQ followed by a late ack
        imiss = 1'b1; iaddr = 32'h0000_8000;
        tick();
        chk("rq_req_up", 64'(mem_req), 64'(1));
        rst = 1'b1;
        tick();
        chk("rq_req_low", 64'(mem_req), 64'(0));
        chk("rq_nofill", 64'({ifill, dfill}), 64'(0));
        chk("rq_icnt", 64'(imiss_cnt), 64'(0));
        chk("rq_dcnt", 64'(dmiss_cnt), 64'(0));
        rst = 1'b0; imiss = 1'b0; mem_ack = 1'b1; mem_rdata = 64'hFEED_FACE_CAFE_BEEF;
        tick();
        mem_ack = 1'b0;
        chk("late_ack_req", 64'(mem_req), 64'(0));
        chk("late_ack_nofill", 64'({ifill, dfill}), 64'(0));
        chk("late_ack_line", line, 64'(0));
        m_icnt = 0;
        m_dcnt = 0;
`ifdef CACHE_ARB_RR_EN
        m_last_d = 1'b1;
`endif

        // Counter saturation at all-ones
        for (int k = 0; k < 5; k++) begin
            txn(1'b1, 1'b0, 32'h0040_0100 + 32'(k * 8), 32'h0, 0, 0, {$urandom, $urandom}, 64'h0,
                1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk("sat_icnt", 64'(imiss_cnt), 64'(3));

        // Randomized traffic
        for (int t = 0; t < 60; t++) begin
            txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                {$urandom, $urandom}, {$urandom, $urandom},
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cache_miss_arb.md
Name: cache_miss_arb

Overview:
- Miss controller and memory-port arbiter for the split L1: one icache/tags pair and one dcache/tags pair share a single 64-bit line-read memory port.
- Takes the combinational miss outputs of both tags blocks, grants one miss at a time, and fetches the 8-byte line.
- Drives the fill strobe to the granted side's tags and data arrays together, and stalls the pipeline side that is missing.
- Address split used throughout: tag = addr[31:8], idx = addr[7:3], idb = addr[2:0].

Parameters:
- CNT_W, 16, width of each saturating miss counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- imiss  in  1  miss from the instruction tags block; fetch is valid every cycle.
- iaddr  in  32  fetch address; held by the requester while istall=1.
- dvalid  in  1  load or store in progress this cycle.
- dmiss  in  1  miss from the data tags block; meaningful only when dvalid=1.
- daddr  in  32  data address; held while dstall=1.
- mem_req  out  1  line read request.
- mem_addr  out  32  line address {addr[31:3],3'b000}.
- mem_ack  in  1  line data valid on mem_rdata this cycle.
- mem_rdata  in  64  line from memory; byte 0 in [7:0].
- line  out  64  registered line, wired to data_mem of both data arrays.
- ifill  out  1  fill strobe for the icache and its tags.
- dfill  out  1  fill strobe for the dcache and its tags.
- istall  out  1  instruction-side stall.
- dstall  out  1  data-side stall.
- imiss_cnt  out  CNT_W  instruction misses granted.
- dmiss_cnt  out  CNT_W  data misses granted.

Behaviour:
- Reset (synchronous):
  - State goes to IDLE.
  - mem_req, ifill, dfill = 0; mem_addr and line = 0; counters = 0.
  - istall = dstall = 1 while rst is high.
- Stalls are combinational:
  - istall = rst | imiss.
  - dstall = rst | (dvalid & dmiss).
- Request terms: ireq = imiss; dreq = dvalid & dmiss.
- FSM states: IDLE, REQ, FILL.
- IDLE:
  - If dreq: grant D (owner=D), latch the D line address into mem_addr, mem_req<=1, go to REQ.
  - Else if ireq: grant I in the same way.
  - Else stay in IDLE.
  - On a grant, the owner's counter increments, saturating at all-ones.
- REQ:
  - mem_req=1 and mem_addr stay stable until mem_ack.
  - On mem_ack: line<=mem_rdata, mem_req<=0, go to FILL.
- FILL:
  - Exactly one cycle with ifill=1 (owner I) or dfill=1 (owner D); the other strobe stays 0.
  - Next state is IDLE.
  - The tags block updates on this edge, so the owner's miss drops the following cycle.
- Arbitration boundaries:
  - The loser of a simultaneous request waits.
  - It is granted in the IDLE cycle after the winner's FILL, giving one bubble cycle.
  - A requester dropping its miss while not granted is simply not served.
  - A requester dropping its miss after grant does not abort the fetch; the line is still filled.
- Latency: miss seen at cycle 0 in IDLE, mem_req at cycle 1, ack at cycle k≥1, fill at k+1, hit at k+2. Minimum stall is 3 cycles.
- mem_ack is ignored in IDLE and FILL.
- rst in REQ or FILL:
  - Returns to IDLE and drops mem_req.
  - Any fill is suppressed.
  - A late ack is ignored.
- Stores are not handled here: the dcache writes its array on the hit after fill.

Optional Feature:
- Macro: CACHE_ARB_RR_EN.
- When defined: round-robin arbitration with a 1-bit last_owner register.
  - last_owner resets to D, so I wins the first simultaneous request after reset.
  - On a simultaneous request, the side that is not last_owner wins.
  - last_owner updates on each grant.
- When undefined: fixed priority, D over I; no last_owner register.

Test Plan:
- Reset then idle (imiss=0, dvalid=0): mem_req=0, fill strobes=0, counters=0; istall=dstall=1 only while rst=1.
- imiss=1 with iaddr=0x00400014, ack 2 cycles after mem_req, mem_rdata=0x1122334455667788:
  - mem_addr=0x00400010.
  - ifill=1 for exactly one cycle with line=0x1122334455667788.
  - imiss_cnt=1.
- dreq and ireq rise together (daddr=0x10000008, iaddr=0x00400000):
  - D granted first with mem_addr=0x10000008, dfill pulse.
  - One IDLE bubble, then I granted with mem_addr=0x00400000.
  - With CACHE_ARB_RR_EN: I is granted first.
- rst asserted in REQ, then mem_ack the following cycle: no fill strobe, state IDLE, ack ignored, counters cleared.
- Counter saturation with CNT_W=2: four I misses leave imiss_cnt=3; a fifth miss keeps it at 3.
- mem_ack same cycle as mem_req: fill on the next cycle, total stall of 3 cycles.
